// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory, hands the
// fetched word to the IR stage with a one-cycle ir_write_en pulse, then waits
// for the control unit to request the next instruction.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              next_instr,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_valid,
  output logic [DATA_W-1:0] ir_din,
  output logic              ir_write_en,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              mem_err
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, LOAD, HOLD, HALTED
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt;
  logic        timeout_hit;
  logic        is_halt;
  logic        pc_load_ok;
  logic        resume;

  // WAIT has spent TIMEOUT cycles without data; this cycle aborts the fetch
  assign timeout_hit = (state == WAIT) && !mem_valid && (cnt == 8'(TIMEOUT - 1));
  assign is_halt     = (ir_din[DATA_W-1 -: 4] == HALT_OP);
  assign pc_load_ok  = pc_load && (state == IDLE || state == HOLD || state == HALTED);
  assign resume      = start && (state == IDLE || state == HALTED);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = REQ;
      REQ:     state_nx = WAIT;
      WAIT:    if (mem_valid)        state_nx = LOAD;
               else if (timeout_hit) state_nx = IDLE;
      LOAD:    state_nx = is_halt ? HALTED : HOLD;
      HOLD:    if (next_instr) state_nx = REQ;
      HALTED:  if (start) state_nx = REQ;
      default: state_nx = IDLE;
    endcase
  end

  // Moore outputs decoded from state
  always_comb begin
    mem_rd      = (state == REQ);
    mem_addr    = pc;
    ir_write_en = (state == LOAD);
    busy        = (state == REQ) || (state == WAIT) || (state == LOAD);
    halted      = (state == HALTED);
  end

  // Datapath: PC, captured instruction, wait counter, sticky error flag.
  // A pc_load in HOLD takes effect on the same edge that enters REQ, so the
  // following request already presents the loaded address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= '0;
      ir_din  <= '0;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      if (pc_load_ok)
        pc <= pc_load_val;
      else if (state == LOAD && !is_halt)
        pc <= pc + ADDR_W'(1);

      if (state == WAIT && mem_valid)
        ir_din <= mem_data;

      if (state == REQ)
        cnt <= '0;
      else if (state == WAIT && !mem_valid)
        cnt <= cnt + 8'd1;

      if (resume)
        mem_err <= 1'b0;
      else if (timeout_hit)
        mem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, single fetch, PC wrap,
// load/next_instr race, HALT, ignored early mem_valid and memory timeout.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, next_instr, pc_load, mem_valid;
  logic [7:0]  pc_load_val;
  logic [15:0] mem_data;
  logic        mem_rd, ir_write_en, busy, halted, mem_err;
  logic [7:0]  mem_addr, pc;
  logic [15:0] ir_din;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(15), .HALT_OP(4'hF)) dut (
    .clk(clk), .rst(rst), .start(start), .next_instr(next_instr),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid),
    .ir_din(ir_din), .ir_write_en(ir_write_en), .pc(pc), .busy(busy),
    .halted(halted), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 0; next_instr = 0; pc_load = 0; mem_valid = 0;
    pc_load_val = '0; mem_data = '0;
    step(); step();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", pc); end
    checks++; if (ir_din !== 16'h0000) begin errors++; $display("FAIL reset_ir: got %h want 0000", ir_din); end
    checks++; if ({mem_rd, ir_write_en, busy, halted, mem_err} !== 5'b0)
      begin errors++; $display("FAIL reset_flags: got %b want 00000", {mem_rd, ir_write_en, busy, halted, mem_err}); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single_fetch();
    int pulses = 0;
    start = 1; step(); start = 0;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 8'h00)
      begin errors++; $display("FAIL sf_req: mem_rd=%b addr=%h want 1/00", mem_rd, mem_addr); end
    pulses += int'(ir_write_en);
    step();
    pulses += int'(ir_write_en);
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL sf_rd_once: got %b want 0", mem_rd); end
    mem_valid = 1; mem_data = 16'h1234; step(); mem_valid = 0;
    checks++; if (ir_write_en !== 1'b1 || ir_din !== 16'h1234)
      begin errors++; $display("FAIL sf_load: we=%b ir=%h want 1/1234", ir_write_en, ir_din); end
    pulses += int'(ir_write_en);
    step();
    pulses += int'(ir_write_en);
    checks++; if (pc !== 8'h01 || busy !== 1'b0)
      begin errors++; $display("FAIL sf_hold: pc=%h busy=%b want 01/0", pc, busy); end
    step();
    pulses += int'(ir_write_en);
    checks++; if (pulses != 1) begin errors++; $display("FAIL sf_pulses: got %0d want 1", pulses); end
    checks++; if (ir_din !== 16'h1234) begin errors++; $display("FAIL sf_ir_hold: got %h want 1234", ir_din); end
  endtask

  task automatic test_reset_mid();
    next_instr = 1; step(); next_instr = 0;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 8'h01)
      begin errors++; $display("FAIL rm_req: mem_rd=%b addr=%h want 1/01", mem_rd, mem_addr); end
    step();
    mem_valid = 1; mem_data = 16'h5555;
    #2 rst = 1'b0; #1;
    checks++; if (pc !== 8'h00 || mem_rd !== 1'b0 || ir_write_en !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL rm_abort: pc=%h rd=%b we=%b busy=%b want 00/0/0/0", pc, mem_rd, ir_write_en, busy); end
    step();
    checks++; if (ir_write_en !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL rm_after: we=%b busy=%b want 0/0", ir_write_en, busy); end
    mem_valid = 0;
    rst = 1'b1; step();
  endtask

  task automatic test_wrap();
    pc_load = 1; pc_load_val = 8'hFF; step(); pc_load = 0;
    checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL wr_load_idle: got %h want ff", pc); end
    start = 1; step(); start = 0;
    checks++; if (mem_addr !== 8'hFF || mem_rd !== 1'b1)
      begin errors++; $display("FAIL wr_addr: addr=%h rd=%b want ff/1", mem_addr, mem_rd); end
    step();
    mem_valid = 1; mem_data = 16'h0001; step(); mem_valid = 0;
    step();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL wr_pc: got %h want 00", pc); end
  endtask

  task automatic test_branch_race();
    pc_load = 1; pc_load_val = 8'h40; next_instr = 1; step();
    pc_load = 0; next_instr = 0;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 8'h40)
      begin errors++; $display("FAIL br_addr: rd=%b addr=%h want 1/40", mem_rd, mem_addr); end
  endtask

  task automatic test_halt();
    step();
    mem_valid = 1; mem_data = 16'hF000; step(); mem_valid = 0;
    checks++; if (ir_write_en !== 1'b1) begin errors++; $display("FAIL ht_pulse: got %b want 1", ir_write_en); end
    step();
    checks++; if (halted !== 1'b1 || pc !== 8'h40 || busy !== 1'b0)
      begin errors++; $display("FAIL ht_state: halted=%b pc=%h busy=%b want 1/40/0", halted, pc, busy); end
    next_instr = 1; step(); next_instr = 0;
    checks++; if (halted !== 1'b1 || mem_rd !== 1'b0)
      begin errors++; $display("FAIL ht_next_ignored: halted=%b rd=%b want 1/0", halted, mem_rd); end
    start = 1; step(); start = 0;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 8'h40 || halted !== 1'b0)
      begin errors++; $display("FAIL ht_refetch: rd=%b addr=%h halted=%b want 1/40/0", mem_rd, mem_addr, halted); end
    step();
    pc_load = 1; pc_load_val = 8'h77; step(); pc_load = 0;
    mem_valid = 1; mem_data = 16'h1111; step(); mem_valid = 0;
    step();
    checks++; if (pc !== 8'h41) begin errors++; $display("FAIL ht_load_ignored_wait: pc=%h want 41", pc); end
  endtask

  task automatic test_early_valid();
    next_instr = 1; step(); next_instr = 0;
    mem_valid = 1; mem_data = 16'hAAAA; step();
    mem_valid = 0; step();
    checks++; if (ir_write_en !== 1'b0 || busy !== 1'b1 || ir_din !== 16'h1111)
      begin errors++; $display("FAIL ev_ignored: we=%b busy=%b ir=%h want 0/1/1111", ir_write_en, busy, ir_din); end
    mem_valid = 1; mem_data = 16'hBBBB; step(); mem_valid = 0;
    checks++; if (ir_write_en !== 1'b1 || ir_din !== 16'hBBBB)
      begin errors++; $display("FAIL ev_accept: we=%b ir=%h want 1/bbbb", ir_write_en, ir_din); end
    step();
  endtask

  task automatic test_timeout();
    int early = 0;
    int pulses = 0;
    next_instr = 1; step(); next_instr = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (busy !== 1'b1 || mem_err !== 1'b0) early++;
      pulses += int'(ir_write_en);
    end
    checks++; if (early != 0) begin errors++; $display("FAIL to_early: %0d bad wait cycles want 0", early); end
    step();
    pulses += int'(ir_write_en);
    checks++; if (mem_err !== 1'b1 || busy !== 1'b0 || halted !== 1'b0)
      begin errors++; $display("FAIL to_abort: err=%b busy=%b halted=%b want 1/0/0", mem_err, busy, halted); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL to_no_pulse: got %0d want 0", pulses); end
    checks++; if (pc !== 8'h42) begin errors++; $display("FAIL to_pc: got %h want 42", pc); end
    step();
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", mem_err); end
    start = 1; step(); start = 0;
    checks++; if (mem_err !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 8'h42)
      begin errors++; $display("FAIL to_clear: err=%b rd=%b addr=%h want 0/1/42", mem_err, mem_rd, mem_addr); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_reset_mid();
    test_wrap();
    test_branch_race();
    test_halt();
    test_early_valid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
